// File: rtl/cntr_chk_pkg.sv
// Shared types and error codes for the synchronous counter checker.
package cntr_chk_pkg;

   localparam int unsigned CODE_W = 2;

   typedef enum logic [1:0] {
      ACQ    = 2'b00,
      SYNC   = 2'b01,
      LOCKED = 2'b10
   } state_t;

   localparam logic [CODE_W-1:0] ERR_NONE  = 2'b00;
   localparam logic [CODE_W-1:0] ERR_VAL   = 2'b01;
   localparam logic [CODE_W-1:0] ERR_CARRY = 2'b10;
   localparam logic [CODE_W-1:0] ERR_BOTH  = 2'b11;

   // Map the two mismatch flags onto the reported error code.
   function automatic logic [CODE_W-1:0] err_encode(input logic val_err, input logic carry_err);
      logic [CODE_W-1:0] code;
      code = ERR_NONE;
      if (val_err && carry_err) code = ERR_BOTH;
      else if (val_err)         code = ERR_VAL;
      else if (carry_err)       code = ERR_CARRY;
      return code;
   endfunction

endpackage

// File: rtl/sat_cntr.sv
// Saturating up-counter with synchronous clear.
module sat_cntr #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/sync_cntr_checker.sv
// Tracks a synchronous counter's count/carry against a one-sample-delayed
// prediction; reports mismatches, counts errors and wraps, and flags lock.
module sync_cntr_checker
   import cntr_chk_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned LOCK_N      = 4,
   parameter int unsigned ERR_W       = 8,
   parameter bit          CARRY_GATED = 1'b1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              clr,
   input  logic              cnt_en,
   input  logic [WIDTH-1:0]  count,
   input  logic              carry,
   output logic              locked,
   output logic              err_pulse,
   output logic [CODE_W-1:0] err_code,
   output logic [ERR_W-1:0]  err_count,
   output logic [7:0]        wrap_count
);

   localparam int unsigned GOOD_W = 4;
   localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_N - 1);

   state_t            state;
   logic [WIDTH-1:0]  ref_cnt;
   logic              ref_en;
   logic [GOOD_W-1:0] good_cnt;

   logic [WIDTH-1:0]  exp_cnt_c;
   logic              exp_carry_c;
   logic              check_c;
   logic              val_err_c;
   logic              carry_err_c;
   logic              err_c;
   logic              wrap_c;

   // Prediction and comparison against the current sample.
   always_comb begin
      exp_cnt_c   = ref_en ? (ref_cnt + WIDTH'(1)) : ref_cnt;
      exp_carry_c = CARRY_GATED ? ((&count) & cnt_en) : (&count);
      check_c     = (state != ACQ);
      val_err_c   = check_c && (count != exp_cnt_c);
      carry_err_c = check_c && (carry != exp_carry_c);
      err_c       = val_err_c || carry_err_c;
      wrap_c      = check_c && ref_en && (&ref_cnt) && (count == '0);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= ACQ;
         ref_cnt    <= '0;
         ref_en     <= 1'b0;
         good_cnt   <= '0;
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         err_code   <= ERR_NONE;
         wrap_count <= '0;
      end else if (clr) begin
         state      <= ACQ;
         ref_cnt    <= '0;
         ref_en     <= 1'b0;
         good_cnt   <= '0;
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         err_code   <= ERR_NONE;
         wrap_count <= '0;
      end else begin
         ref_cnt   <= count;
         ref_en    <= cnt_en;
         err_pulse <= err_c;
         if (err_c) err_code <= err_encode(val_err_c, carry_err_c);
         if (wrap_c) wrap_count <= wrap_count + 8'(1);
         unique case (state)
            ACQ: begin
               state    <= SYNC;
               good_cnt <= '0;
               locked   <= 1'b0;
            end
            SYNC: begin
               locked <= 1'b0;
               if (err_c) begin
                  good_cnt <= '0;
               end else if (good_cnt == GOOD_LAST) begin
                  state    <= LOCKED;
                  good_cnt <= '0;
                  locked   <= 1'b1;
               end else begin
                  good_cnt <= good_cnt + GOOD_W'(1);
               end
            end
            LOCKED: begin
               if (err_c) begin
                  state    <= SYNC;
                  good_cnt <= '0;
                  locked   <= 1'b0;
               end
            end
            default: begin
               state    <= ACQ;
               good_cnt <= '0;
               locked   <= 1'b0;
            end
         endcase
      end
   end

   // Mismatch counter; clear overrides an error on the same edge.
   sat_cntr #(
      .WIDTH (ERR_W)
   ) u_err_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (clr),
      .inc   (err_c),
      .count (err_count)
   );

endmodule
